// File: rtl/ones_generator.sv
// Thermometer-code generator: shifts one '1' per cycle into a WIDTH-bit word
// until it holds min(cnt, WIDTH) set low-order bits, then pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for go; out/ovf hold the previous result
// RUN     | shifting in ones until the captured count reaches zero
// DONE    | one-cycle done pulse; out/ovf valid
module ones_generator #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    output logic [WIDTH-1:0]           out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [CW-1:0]    ctr_q, ctr_d;
    logic             ovf_q, ovf_d;
    logic             cnt_over;

    assign cnt_over = (cnt > WIDTH_C);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        ctr_d   = ctr_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    ctr_d   = cnt_over ? WIDTH_C : cnt;
                    ovf_d   = cnt_over;
                    num_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctr_q != '0) begin
                    num_d = {num_q[WIDTH-2:0], 1'b1};
                    ctr_d = ctr_q - ONE_C;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            ctr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            ctr_q   <= ctr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign ovf  = ovf_q;
    assign out  = num_q;

endmodule

// File: tb/tb_ones_generator.sv
// Scoreboard bench for ones_generator (WIDTH=8): expectations are queued when
// an operation is accepted and checked by a monitor on every done pulse.
module tb_ones_generator;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             go;
    logic [3:0]       cnt;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [WIDTH-1:0] out;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;
    int   done_seen;

    ones_generator #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .cnt  (cnt),
        .busy (busy),
        .done (done),
        .ovf  (ovf),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_n(input int c);
        return (c > WIDTH) ? WIDTH : c;
    endfunction

    function automatic logic [WIDTH-1:0] thermo(input int n);
        logic [WIDTH:0] t;
        t = ({{WIDTH{1'b0}}, 1'b1} << n) - 1'b1;
        return t[WIDTH-1:0];
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_seen = done_seen + 1;
            total = total + 1;
            if (sb_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected_done out=%h ovf=%b expected no done", out, ovf);
            end else begin
                e = sb_q.pop_front();
                if (out !== e.out || ovf !== e.ovf) begin
                    bad = bad + 1;
                    $display("FAIL sb_result out=%h ovf=%b expected out=%h ovf=%b", out, ovf, e.out, e.ovf);
                end
            end
        end
    end

    // Drives a one-cycle go (DUT must be IDLE); returns at the negedge after the accept edge.
    task automatic start_op(input int c);
        exp_t e;
        @(negedge clk);
        go  = 1'b1;
        cnt = 4'(c);
        e.out = thermo(sat_n(c));
        e.ovf = (c > WIDTH);
        sb_q.push_back(e);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        go  = 1'b0;
        cnt = '0;
        #3;
        total = total + 1;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_async out=%h busy=%b done=%b ovf=%b expected all zero", out, busy, done, ovf);
        end
        go = 1'b1;
        cnt = 4'd5;
        repeat (3) @(negedge clk);
        total = total + 1;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_held out=%h busy=%b done=%b ovf=%b expected all zero", out, busy, done, ovf);
        end
        go = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        start_op(3);
        total = total + 1;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL basic_busy_accept busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        wait_done(n);
        total = total + 1;
        if (n !== 4) begin
            bad = bad + 1;
            $display("FAIL basic_latency cycles=%0d expected 4", n);
        end
        total = total + 1;
        if (busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL basic_busy_done busy=%b expected 1", busy);
        end
        @(negedge clk);
        total = total + 1;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h07) begin
            bad = bad + 1;
            $display("FAIL basic_after busy=%b done=%b out=%h expected 0 0 07", busy, done, out);
        end
    endtask

    task automatic test_bounds;
        int n;
        start_op(0);
        wait_done(n);
        total = total + 1;
        if (n !== 1 || out !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL zero_cnt cycles=%0d out=%h expected 1 00", n, out);
        end
        @(negedge clk);
        start_op(8);
        wait_done(n);
        total = total + 1;
        if (n !== 9 || out !== 8'hFF || ovf !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL full_cnt cycles=%0d out=%h ovf=%b expected 9 ff 0", n, out, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int n;
        start_op(12);
        wait_done(n);
        total = total + 1;
        if (n !== 9 || out !== 8'hFF || ovf !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL ovf_result cycles=%0d out=%h ovf=%b expected 9 ff 1", n, out, ovf);
        end
        repeat (5) @(negedge clk);
        total = total + 1;
        if (out !== 8'hFF || ovf !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL ovf_hold out=%h ovf=%b expected ff 1", out, ovf);
        end
        start_op(2);
        total = total + 1;
        if (ovf !== 1'b0 || out !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL ovf_clear out=%h ovf=%b expected 00 0", out, ovf);
        end
        wait_done(n);
        total = total + 1;
        if (out !== 8'h03) begin
            bad = bad + 1;
            $display("FAIL ovf_next out=%h expected 03", out);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_go;
        int n;
        start_op(5);
        for (int i = 0; i < 3; i++) begin
            go  = ~go;
            cnt = 4'd1;
            @(negedge clk);
        end
        go = 1'b0;
        wait_done(n);
        total = total + 1;
        if (n !== 3 || out !== 8'h1F) begin
            bad = bad + 1;
            $display("FAIL ignore_go cycles_left=%0d out=%h expected 3 1f", n, out);
        end
        repeat (3) @(negedge clk);
        total = total + 1;
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL ignore_go_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   n;
        int   gap;
        e.out = 8'h03;
        e.ovf = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) sb_q.push_back(e);
        go  = 1'b1;
        cnt = 4'd2;
        @(negedge clk);
        wait_done(n);
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            @(negedge clk);
            gap = 1;
            wait_done(n);
            gap = gap + n;
            if (k == 1) go = 1'b0;
            total = total + 1;
            if (gap !== 5) begin
                bad = bad + 1;
                $display("FAIL b2b_gap pulse=%0d gap=%0d expected 5", k, gap);
            end
        end
        repeat (6) @(negedge clk);
        total = total + 1;
        if (sb_q.size() !== 0 || busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL b2b_drain pending=%0d busy=%b expected 0 0", sb_q.size(), busy);
        end
    endtask

    task automatic test_async_reset;
        int n;
        int seen;
        start_op(6);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total = total + 1;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midrun_reset out=%h busy=%b done=%b ovf=%b expected all zero", out, busy, done, ovf);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = done_seen;
        repeat (10) @(negedge clk);
        total = total + 1;
        if (done_seen !== seen) begin
            bad = bad + 1;
            $display("FAIL midrun_no_done pulses=%0d expected 0", done_seen - seen);
        end
        start_op(2);
        wait_done(n);
        total = total + 1;
        if (n !== 3 || out !== 8'h03) begin
            bad = bad + 1;
            $display("FAIL post_reset cycles=%0d out=%h expected 3 03", n, out);
        end
        @(negedge clk);
    endtask

    task automatic test_round_trip;
        int n;
        for (int c = 0; c < 16; c++) begin
            start_op(c);
            wait_done(n);
            total = total + 1;
            if ($countones(out) !== sat_n(c) || n !== sat_n(c) + 1) begin
                bad = bad + 1;
                $display("FAIL round_trip cnt=%0d popcount=%0d cycles=%0d expected %0d %0d",
                         c, $countones(out), n, sat_n(c), sat_n(c) + 1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        done_seen = 0;
        test_reset();
        test_basic();
        test_bounds();
        test_overflow();
        test_ignore_go();
        test_back_to_back();
        test_async_reset();
        test_round_trip();
        repeat (3) @(negedge clk);
        total = total + 1;
        if (sb_q.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL sb_leftover pending=%0d expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
